sdram_frame_reader: RTL and testbench

Read-side frame sequencer sitting directly downstream of the SDRAM top's user read port (FIFO port 0). It sequences one frame: pulses `rd_rst`, enables SDRAM reads, waits a fixed prefill time, then drains the read FIFO through a 2-entry skid buffer onto a valid/ready pixel stream. Line and frame markers are generated from H/V counters. Everything runs in the SDRAM controller clock domain.

---
 rtl/sdram_frame_reader_if.sv | 32 +++
 rtl/sdram_frame_reader.sv | 222 ++++++++++++++++++++++
 tb/tb_sdram_frame_reader.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_frame_reader_if.sv
// Read-FIFO pop port and pixel stream of the SDRAM frame reader.
// master: the frame reader; slave: the FIFO / pixel sink side.
`timescale 1ns/1ps
interface sdram_frame_reader_if;
    logic        rd_fifo_rd_req;
    logic [15:0] rd_fifo_rd_data;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        line_end;
    logic        frame_end;

    modport master (
        output rd_fifo_rd_req,
        input  rd_fifo_rd_data,
        output pix_data,
        output pix_valid,
        input  pix_ready,
        output line_end,
        output frame_end
    );

    modport slave (
        input  rd_fifo_rd_req,
        output rd_fifo_rd_data,
        input  pix_data,
        input  pix_valid,
        output pix_ready,
        input  line_end,
        input  frame_end
    );
endinterface

// File: rtl/sdram_frame_reader.sv
// Read-side frame sequencer for the SDRAM user read port: pulses rd_rst,
// enables reads, waits a prefill time, then drains the read FIFO through a
// 2-entry skid buffer onto a valid/ready pixel stream with line/frame markers.
// Optional feature macro: RD_FRAME_ABORT_EN (frame_start during a frame
// aborts it and restarts the sequence); undefined means frame_start is ignored
// while busy.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | SDRAM not initialised, everything held quiet
// ST_WAIT    | initialised, waiting for frame_start
// ST_RESET   | rd_rst high for RST_CYC cycles
// ST_PREFILL | read_valid high, PREFILL_CYC cycles before the first pop
// ST_STREAM  | popping the FIFO and streaming pixels until frame end
`timescale 1ns/1ps
module sdram_frame_reader #(
    parameter int H_PIX       = 640,
    parameter int V_LINES     = 480,
    parameter int RST_CYC     = 4,
    parameter int PREFILL_CYC = 64
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 init_end,
    input  logic                 frame_start,
    output logic                 rd_rst,
    output logic                 read_valid,
    output logic                 busy,
    sdram_frame_reader_if.master bus
);
    localparam int TOTAL   = H_PIX * V_LINES;
    localparam int REQ_W   = $clog2(TOTAL + 1);
    localparam int TMR_MAX = (RST_CYC > PREFILL_CYC) ? RST_CYC : PREFILL_CYC;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int XW      = (H_PIX > 1) ? $clog2(H_PIX) : 1;
    localparam int YW      = (V_LINES > 1) ? $clog2(V_LINES) : 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WAIT    = 3'd1;
    localparam logic [2:0] ST_RESET   = 3'd2;
    localparam logic [2:0] ST_PREFILL = 3'd3;
    localparam logic [2:0] ST_STREAM  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [REQ_W-1:0] req_cnt_q, req_cnt_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [1:0]       occ_q, occ_d;
    logic             inflight_q, inflight_d;
    logic [15:0]      buf0_q, buf0_d;
    logic [15:0]      buf1_q, buf1_d;

    logic       pix_valid;
    logic       xfer;
    logic       last_x;
    logic       last_y;
    logic       line_end;
    logic       frame_end;
    logic       credit_ok;
    logic       rd_req;
    logic       abort;
    logic [1:0] slot;
    logic [2:0] pending;

    assign pix_valid = (occ_q != 2'd0);
    assign xfer      = pix_valid & bus.pix_ready;
    assign last_x    = (x_q == XW'(H_PIX - 1));
    assign last_y    = (y_q == YW'(V_LINES - 1));
    assign line_end  = pix_valid & last_x;
    assign frame_end = line_end & last_y;

    // Words that will be held after this cycle's pop, counting the word in flight.
    assign pending   = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, xfer};
    assign credit_ok = (pending <= 3'd1);
    assign rd_req    = init_end && (state_q == ST_STREAM) &&
                       (req_cnt_q < REQ_W'(TOTAL)) && credit_ok;

    // Buffer position the arriving word lands in, after this cycle's pop.
    assign slot = occ_q - {1'b0, xfer};

    assign rd_rst     = (state_q == ST_RESET);
    assign read_valid = (state_q == ST_PREFILL) || (state_q == ST_STREAM);
    assign busy       = rd_rst || read_valid;

`ifdef RD_FRAME_ABORT_EN
    assign abort = frame_start & busy;
`else
    assign abort = 1'b0;
`endif

    assign bus.rd_fifo_rd_req = rd_req;
    assign bus.pix_data       = buf0_q;
    assign bus.pix_valid      = pix_valid;
    assign bus.line_end       = line_end;
    assign bus.frame_end      = frame_end;

    // Next-state: sequencing FSM, skid buffer and pixel/request counters.
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        req_cnt_d  = req_cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        inflight_d = rd_req;
        occ_d      = slot + {1'b0, inflight_q};

        if (xfer) begin
            buf0_d = buf1_q;
        end
        if (inflight_q) begin
            if (slot == 2'd0) begin
                buf0_d = bus.rd_fifo_rd_data;
            end else begin
                buf1_d = bus.rd_fifo_rd_data;
            end
        end

        if (rd_req) begin
            req_cnt_d = req_cnt_q + REQ_W'(1);
        end

        if (xfer) begin
            if (last_x) begin
                x_d = '0;
                y_d = last_y ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (init_end) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (frame_start) begin
                    state_d   = ST_RESET;
                    tmr_d     = TMR_W'(RST_CYC - 1);
                    req_cnt_d = '0;
                    x_d       = '0;
                    y_d       = '0;
                end
            end
            ST_RESET: begin
                if (tmr_q == '0) begin
                    state_d = ST_PREFILL;
                    tmr_d   = TMR_W'(PREFILL_CYC - 1);
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_PREFILL: begin
                if (tmr_q == '0) begin
                    state_d = ST_STREAM;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_STREAM: begin
                if (xfer && frame_end) begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort restarts the sequence; the word still in flight is dropped.
        if (abort) begin
            state_d    = ST_RESET;
            tmr_d      = TMR_W'(RST_CYC - 1);
            req_cnt_d  = '0;
            x_d        = '0;
            y_d        = '0;
            occ_d      = 2'd0;
            inflight_d = 1'b0;
            buf0_d     = '0;
            buf1_d     = '0;
        end

        if (!init_end) begin
            state_d    = ST_IDLE;
            tmr_d      = '0;
            req_cnt_d  = '0;
            x_d        = '0;
            y_d        = '0;
            occ_d      = 2'd0;
            inflight_d = 1'b0;
            buf0_d     = '0;
            buf1_d     = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            req_cnt_q  <= '0;
            x_q        <= '0;
            y_q        <= '0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            req_cnt_q  <= req_cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end
endmodule

// File: tb/tb_sdram_frame_reader.sv
// Directed bench for sdram_frame_reader on a 4x2 frame.
`timescale 1ns/1ps
module tb_sdram_frame_reader;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int RC = 4;
    localparam int PC = 64;

    logic sys_clk     = 1'b0;
    logic sys_rst_n   = 1'b0;
    logic init_end    = 1'b0;
    logic frame_start = 1'b0;
    logic rd_rst;
    logic read_valid;
    logic busy;

    sdram_frame_reader_if bus();

    sdram_frame_reader #(
        .H_PIX(H), .V_LINES(V), .RST_CYC(RC), .PREFILL_CYC(PC)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .init_end    (init_end),
        .frame_start (frame_start),
        .rd_rst      (rd_rst),
        .read_valid  (read_valid),
        .busy        (busy),
        .bus         (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // FIFO model: pops return 0,1,2,... one cycle after the request; rd_rst restarts the sequence.
    logic [15:0] fifo_cnt;
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fifo_cnt            <= 16'd0;
            bus.rd_fifo_rd_data <= 16'd0;
        end else if (rd_rst) begin
            fifo_cnt <= 16'd0;
        end else if (bus.rd_fifo_rd_req) begin
            bus.rd_fifo_rd_data <= fifo_cnt;
            fifo_cnt            <= fifo_cnt + 16'd1;
        end
    end

    logic rdy_fix = 1'b1;
    logic tgl_en  = 1'b0;
    logic tgl     = 1'b0;
    always @(posedge sys_clk) tgl <= ~tgl;
    assign bus.pix_ready = tgl_en ? tgl : rdy_fix;

    // Monitor, sampled on the falling edge.
    logic        mon_clr = 1'b0;
    int          nx, nreq, nrst, nrv, nfe, stalls, hold_err, max_out;
    int          first_req, first_rst, first_rv, first_pv, last_busy;
    logic [15:0] xd  [0:31];
    logic        xle [0:31];
    logic        xfe [0:31];
    int          xc  [0:31];
    logic        hold_v;
    logic [15:0] hold_d;

    always @(negedge sys_clk) begin
        if (mon_clr || !sys_rst_n) begin
            nx = 0; nreq = 0; nrst = 0; nrv = 0; nfe = 0;
            stalls = 0; hold_err = 0; max_out = 0;
            first_req = -1; first_rst = -1; first_rv = -1; first_pv = -1; last_busy = -1;
            hold_v = 1'b0; hold_d = 16'd0;
        end else begin
            if (bus.rd_fifo_rd_req) begin
                if (nreq == 0) first_req = cyc;
                nreq++;
            end
            if (rd_rst) begin
                if (nrst == 0) first_rst = cyc;
                nrst++;
            end
            if (read_valid) begin
                if (nrv == 0) first_rv = cyc;
                nrv++;
            end
            if (bus.pix_valid && first_pv < 0) first_pv = cyc;
            if (busy) last_busy = cyc;
            if (hold_v && (!bus.pix_valid || bus.pix_data != hold_d)) hold_err++;
            hold_v = bus.pix_valid & ~bus.pix_ready;
            hold_d = bus.pix_data;
            if (hold_v) stalls++;
            if (bus.pix_valid && bus.pix_ready) begin
                if (nx < 32) begin
                    xd[nx]  = bus.pix_data;
                    xle[nx] = bus.line_end;
                    xfe[nx] = bus.frame_end;
                    xc[nx]  = cyc;
                end
                if (bus.frame_end) nfe++;
                nx++;
            end
            if (nreq - nx > max_out) max_out = nreq - nx;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic mon_clear();
        mon_clr = 1'b1;
        tick(1);
        mon_clr = 1'b0;
    endtask

    task automatic pulse_start(output int t);
        t = cyc;
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic wait_nx(input int n, input int budget, input string tag);
        int k = 0;
        while (nx < n && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, 32'(nx >= n), 32'd1);
    endtask

    task automatic check_outputs_low(input string tag);
        check({tag, "_rd_rst"},     32'(rd_rst),             32'd0);
        check({tag, "_read_valid"}, 32'(read_valid),         32'd0);
        check({tag, "_busy"},       32'(busy),               32'd0);
        check({tag, "_rd_req"},     32'(bus.rd_fifo_rd_req), 32'd0);
        check({tag, "_pix_valid"},  32'(bus.pix_valid),      32'd0);
        check({tag, "_line_end"},   32'(bus.line_end),       32'd0);
        check({tag, "_frame_end"},  32'(bus.frame_end),      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int t;
    int k;

    initial begin
        // Reset state
        tick(3);
        check_outputs_low("reset");
        check("reset_pix_data", 32'(bus.pix_data), 32'd0);

        // Init gating: frame_start with init_end low does nothing
        sys_rst_n = 1'b1;
        tick(2);
        pulse_start(t);
        tick(10);
        check("gate_activity", 32'(nrst + nrv + nreq), 32'd0);
        check("gate_busy", 32'(busy), 32'd0);

        // Small frame with pix_ready held high, including latency
        init_end = 1'b1;
        tick(2);
        mon_clear();
        pulse_start(t);
        wait_nx(8, 200, "frame1_done");
        tick(3);
        check("lat_rd_rst_first", 32'(first_rst), 32'(t + 1));
        check("lat_rd_rst_len", 32'(nrst), 32'd4);
        check("lat_read_valid", 32'(first_rv), 32'(t + RC + 1));
        check("lat_first_req", 32'(first_req), 32'(t + RC + PC + 1));
        check("lat_first_pv", 32'(first_pv), 32'(t + RC + PC + 3));
        check("f1_nreq", 32'(nreq), 32'd8);
        check("f1_nx", 32'(nx), 32'd8);
        check("f1_no_bubbles", 32'(xc[7] - xc[0]), 32'd7);
        check("f1_busy_fall", 32'(last_busy), 32'(xc[7]));
        check("f1_busy_now", 32'(busy), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("f1_data%0d", i), 32'(xd[i]), 32'(i));
            check($sformatf("f1_le%0d", i), 32'(xle[i]), 32'((i % H) == H - 1));
            check($sformatf("f1_fe%0d", i), 32'(xfe[i]), 32'(i == 7));
        end

        // Backpressure: pix_ready toggles every cycle
        mon_clear();
        tgl_en = 1'b1;
        pulse_start(t);
        wait_nx(8, 400, "bp_done");
        tick(3);
        tgl_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("bp_data%0d", i), 32'(xd[i]), 32'(i));
        end
        check("bp_nx", 32'(nx), 32'd8);
        check("bp_nreq", 32'(nreq), 32'd8);
        check("bp_stalls_seen", 32'(stalls != 0), 32'd1);
        check("bp_hold", 32'(hold_err), 32'd0);
        check("bp_outstanding", 32'(max_out <= 2), 32'd1);
        check("bp_nfe", 32'(nfe), 32'd1);

        // Abort: frame_start after 3 pixels, with the stream stalled that cycle
        mon_clear();
        pulse_start(t);
        k = 0;
        while (nx < 3 && k < 200) begin
            tick(1);
            k++;
        end
        check("ab_pre", 32'(nx), 32'd3);
        rdy_fix = 1'b0;
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        rdy_fix = 1'b1;
`ifdef RD_FRAME_ABORT_EN
        wait_nx(11, 300, "ab_done");
        tick(3);
        check("ab_nx", 32'(nx), 32'd11);
        check("ab_nrst", 32'(nrst), 32'd8);
        check("ab_nfe", 32'(nfe), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ab_data%0d", i), 32'(xd[3 + i]), 32'(i));
            check($sformatf("ab_le%0d", i), 32'(xle[3 + i]), 32'((i % H) == H - 1));
        end
        check("ab_fe_last", 32'(xfe[10]), 32'd1);
`else
        wait_nx(8, 300, "ab_done");
        tick(3);
        check("ab_nx", 32'(nx), 32'd8);
        check("ab_nrst", 32'(nrst), 32'd4);
        check("ab_nfe", 32'(nfe), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ab_data%0d", i), 32'(xd[i]), 32'(i));
        end
        check("ab_fe_last", 32'(xfe[7]), 32'd1);
`endif
        check("ab_busy_now", 32'(busy), 32'd0);

        // Asynchronous reset during STREAM
        mon_clear();
        pulse_start(t);
        wait_nx(2, 200, "ar_stream");
        @(negedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_outputs_low("ar_immediate");
        tick(1);
        sys_rst_n = 1'b1;
        mon_clear();
        tick(8);
        check("ar_no_pulse", 32'(nrst), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        init_end = 1'b0;
        tick(2);
        mon_clear();
        pulse_start(t);
        tick(8);
        check("ar_gate_rd_rst", 32'(nrst), 32'd0);
        init_end = 1'b1;
        tick(2);
        mon_clear();
        pulse_start(t);
        tick(8);
        check("ar_restart_len", 32'(nrst), 32'd4);
        check("ar_restart_first", 32'(first_rst), 32'(t + 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
